// File: rtl/mvm_prog_sequencer.sv
// Job sequencer feeding an MVM rx port: streams RF write beats, an optional
// input-vector beat and one instruction beat per accepted command.
module mvm_prog_sequencer #(
  parameter int DATAW   = 512,
  parameter int USERW   = 75,
  parameter int DESTW   = 12,
  parameter int RFADDRW = 9,
  parameter int INSTW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [RFADDRW-1:0] cmd_rf_base,
  input  logic [RFADDRW:0]   cmd_rf_count,
  input  logic               cmd_has_input,
  input  logic [INSTW-1:0]   cmd_inst,
  input  logic [DESTW-1:0]   cmd_dest,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [DATAW-1:0]   data,
  output logic               tx_tvalid,
  output logic [DATAW-1:0]   tx_tdata,
  output logic [USERW-1:0]   tx_tuser,
  output logic [DESTW-1:0]   tx_tdest,
  output logic               tx_tlast,
  input  logic               tx_tready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {S_IDLE, S_RF, S_INP, S_INST, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [RFADDRW-1:0]   r_addr;
  logic [RFADDRW:0]     r_cnt;
  logic                 r_has_input;
  logic [INSTW-1:0]     r_inst;
  logic [DESTW-1:0]     r_dest;
  logic                 r_done, r_err;
  logic                 r_tvalid, r_tlast;
  logic [DATAW-1:0]     r_tdata;
  logic [USERW-1:0]     r_tuser;
  logic [DESTW-1:0]     r_tdest;

  logic                 w_can_load, w_cmd_hs, w_bad_cnt, w_data_hs, w_load;
  logic [DATAW-1:0]     w_tdata;
  logic [USERW-1:0]     w_tuser;

  assign w_can_load = !r_tvalid || tx_tready;
  assign cmd_ready  = (r_state == S_IDLE) && !rst;
  assign w_cmd_hs   = cmd_valid && cmd_ready;
  // Anything above 2^RFADDRW: top bit set with any lower bit set.
  assign w_bad_cnt  = cmd_rf_count[RFADDRW] && |cmd_rf_count[RFADDRW-1:0];
  assign data_ready = w_can_load &&
                      (((r_state == S_RF) && (r_cnt != '0)) || (r_state == S_INP));
  assign w_data_hs  = data_valid && data_ready;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign tx_tvalid  = r_tvalid;
  assign tx_tdata   = r_tdata;
  assign tx_tuser   = r_tuser;
  assign tx_tdest   = r_tdest;
  assign tx_tlast   = r_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_tdata = '0;
    w_tuser = '0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs && !w_bad_cnt) begin
          if (cmd_rf_count != '0) w_next = S_RF;
          else if (cmd_has_input) w_next = S_INP;
          else                    w_next = S_INST;
        end
      end
      S_RF: begin
        w_tdata = data;
        w_tuser = USERW'({1'b1, 2'b11, r_addr});
        if (w_data_hs) begin
          w_load = 1'b1;
          if (r_cnt == (RFADDRW+1)'(1)) w_next = r_has_input ? S_INP : S_INST;
        end
      end
      S_INP: begin
        w_tdata = data;
        w_tuser = USERW'({1'b0, 2'b10, {RFADDRW{1'b0}}});
        if (w_data_hs) begin
          w_load = 1'b1;
          w_next = S_INST;
        end
      end
      S_INST: begin
        w_tdata = DATAW'(r_inst);
        if (w_can_load) begin
          w_load = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (r_tvalid && tx_tready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_has_input <= 1'b0;
      r_inst      <= '0;
      r_dest      <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tuser     <= '0;
      r_tdest     <= '0;
      r_tlast     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_cmd_hs) begin
        r_addr      <= cmd_rf_base;
        r_cnt       <= cmd_rf_count;
        r_has_input <= cmd_has_input;
        r_inst      <= cmd_inst;
        r_dest      <= cmd_dest;
        r_err       <= w_bad_cnt;
      end
      if ((r_state == S_DONE) && r_tvalid && tx_tready) r_done <= 1'b1;
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_tdata;
        r_tuser  <= w_tuser;
        r_tdest  <= r_dest;
        r_tlast  <= 1'b1;
      end else if (tx_tready) begin
        r_tvalid <= 1'b0;
      end
      // Address wraps naturally at 2^RFADDRW.
      if (w_data_hs && (r_state == S_RF)) begin
        r_addr <= r_addr + RFADDRW'(1);
        r_cnt  <= r_cnt - (RFADDRW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_mvm_prog_sequencer.sv
// Directed bench for mvm_prog_sequencer: beat logging monitor, data feeder
// with optional gaps, and one task per scenario.
module tb_mvm_prog_sequencer;
  localparam int DATAW = 512, USERW = 75, DESTW = 12, RFADDRW = 9, INSTW = 32;

  logic               clk = 1'b0, rst = 1'b1;
  logic               cmd_valid = 1'b0, cmd_ready;
  logic [RFADDRW-1:0] cmd_rf_base = '0;
  logic [RFADDRW:0]   cmd_rf_count = '0;
  logic               cmd_has_input = 1'b0;
  logic [INSTW-1:0]   cmd_inst = '0;
  logic [DESTW-1:0]   cmd_dest = '0;
  logic               data_valid = 1'b0, data_ready;
  logic [DATAW-1:0]   data = '0;
  logic               tx_tvalid, tx_tlast, tx_tready = 1'b1;
  logic [DATAW-1:0]   tx_tdata;
  logic [USERW-1:0]   tx_tuser;
  logic [DESTW-1:0]   tx_tdest;
  logic               busy, done, err;

  int checks = 0, errors = 0;

  mvm_prog_sequencer #(.DATAW(DATAW), .USERW(USERW), .DESTW(DESTW),
                       .RFADDRW(RFADDRW), .INSTW(INSTW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rf_base(cmd_rf_base),
    .cmd_rf_count(cmd_rf_count), .cmd_has_input(cmd_has_input),
    .cmd_inst(cmd_inst), .cmd_dest(cmd_dest),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tuser(tx_tuser),
    .tx_tdest(tx_tdest), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Beat log and pulse counters
  logic [11:0]      b_user[$];
  logic [DATAW-1:0] b_data[$];
  logic [DESTW-1:0] b_dest[$];
  logic             b_meta[$];
  int               b_cyc[$];
  int               cyc = 0, done_cnt = 0, err_cnt = 0, stall_viol = 0;
  logic             h_vld = 1'b0;
  logic [DATAW-1:0] h_data;
  logic [USERW-1:0] h_user;
  logic [DESTW-1:0] h_dest;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
    if (!rst && tx_tvalid && tx_tready) begin
      b_user.push_back(tx_tuser[11:0]);
      b_data.push_back(tx_tdata);
      b_dest.push_back(tx_tdest);
      b_meta.push_back(tx_tlast && (tx_tuser[USERW-1:12] == '0));
      b_cyc.push_back(cyc);
    end
    if (!rst && h_vld && (!tx_tvalid || tx_tdata !== h_data || tx_tuser !== h_user ||
                          tx_tdest !== h_dest))
      stall_viol <= stall_viol + 1;
    h_vld  <= !rst && tx_tvalid && !tx_tready;
    h_data <= tx_tdata;
    h_user <= tx_tuser;
    h_dest <= tx_tdest;
  end

  // Data source: test appends at src_n, feeder consumes on handshakes
  logic [DATAW-1:0] src_arr[256];
  int               src_n = 0, src_idx = 0, skip_to = 0, n_cons = 0;
  bit               feed_en = 1'b0, gap_en = 1'b0, rdy_rand = 1'b0;

  initial begin
    bit hs;
    forever begin
      @(posedge clk);
      hs = data_valid && data_ready;
      #1;
      if (hs) begin
        src_idx = src_idx + 1;
        n_cons  = n_cons + 1;
      end
      if (src_idx < skip_to) src_idx = skip_to;
      data_valid = feed_en && (src_idx < src_n) && (!gap_en || ($urandom_range(0, 2) != 0));
      data       = (src_idx < src_n) ? src_arr[src_idx] : '0;
      tx_tready  = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic send_cmd(input logic [RFADDRW-1:0] base, input logic [RFADDRW:0] cnt,
                          input logic has_in, input logic [INSTW-1:0] inst,
                          input logic [DESTW-1:0] dest);
    int n = 0;
    @(posedge clk); #1;
    cmd_rf_base = base; cmd_rf_count = cnt; cmd_has_input = has_in;
    cmd_inst = inst; cmd_dest = dest; cmd_valid = 1'b1;
    do begin @(posedge clk); n++; end while (!cmd_ready && n < 20);
    #1 cmd_valid = 1'b0;
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready never seen within 20 cycles, required 1");
    end
  endtask

  task automatic wait_done(input int d0, input int limit, input string name);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL %s_done: done pulses %0d, required 1", name, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    repeat (3) @(negedge clk);
    obs = {tx_tvalid, tx_tlast, |tx_tdata, |tx_tuser, |tx_tdest,
           cmd_ready, data_ready, busy, done, err};
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required %b", obs, 10'b0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    int b0 = b_user.size(), c0 = n_cons, d0 = done_cnt;
    logic [11:0]      eu[3] = '{12'hE01, 12'h400, 12'h000};
    logic [DATAW-1:0] ed[3];
    ed[0] = DATAW'(8'h01); ed[1] = DATAW'(8'h10); ed[2] = DATAW'(32'h8000_000C);
    src_arr[src_n] = DATAW'(8'h01); src_arr[src_n+1] = DATAW'(8'h10);
    src_arr[src_n+2] = DATAW'(8'h01); src_arr[src_n+3] = DATAW'(8'h10);
    src_n += 4;
    feed_en = 1'b1;
    send_cmd(9'd1, 10'd1, 1'b1, 32'h8000_000C, 12'h2A5);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: busy=%b, required 1", busy);
    end
    wait_done(d0, 40, "basic");
    checks++;
    if (b_user.size() - b0 !== 3) begin
      errors++; $display("FAIL basic_nbeats: got %0d, required 3", b_user.size() - b0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b_user[b0+i] !== eu[i] || b_data[b0+i] !== ed[i] || b_meta[b0+i] !== 1'b1 ||
          b_dest[b0+i] !== 12'h2A5) begin
        errors++;
        $display("FAIL basic_beat%0d: tuser=%h data=%h meta=%b dest=%h, required %h %h 1 2a5",
                 i, b_user[b0+i], b_data[b0+i][31:0], b_meta[b0+i], b_dest[b0+i], eu[i], ed[i][31:0]);
      end
    end
    checks++;
    if (n_cons - c0 !== 2) begin
      errors++; $display("FAIL basic_consumed: got %0d, required 2", n_cons - c0);
    end
    feed_en = 1'b0; skip_to = src_n;
  endtask

  task automatic test_wrap();
    int b0 = b_user.size(), d0 = done_cnt;
    logic [RFADDRW-1:0] ea[4] = '{9'd510, 9'd511, 9'd0, 9'd1};
    for (int i = 0; i < 4; i++) src_arr[src_n+i] = DATAW'(32'hA0 + i);
    src_n += 4;
    feed_en = 1'b1;
    repeat (2) @(negedge clk);
    send_cmd(9'd510, 10'd4, 1'b0, 32'h55, 12'h001);
    wait_done(d0, 40, "wrap");
    checks++;
    if (b_user.size() - b0 !== 5) begin
      errors++; $display("FAIL wrap_nbeats: got %0d, required 5", b_user.size() - b0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b_user[b0+i] !== {1'b1, 2'b11, ea[i]} || b_data[b0+i] !== DATAW'(32'hA0 + i)) begin
        errors++;
        $display("FAIL wrap_beat%0d: tuser=%h data=%h, required %h %h", i, b_user[b0+i],
                 b_data[b0+i][31:0], {1'b1, 2'b11, ea[i]}, 32'hA0 + i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b_cyc[b0+i+1] !== b_cyc[b0+i] + 1) begin
        errors++;
        $display("FAIL wrap_gap%0d: beat cycles %0d -> %0d, required consecutive",
                 i, b_cyc[b0+i], b_cyc[b0+i+1]);
      end
    end
    checks++;
    if (b_user[b0+4] !== 12'h000 || b_data[b0+4] !== DATAW'(32'h55)) begin
      errors++;
      $display("FAIL wrap_inst: tuser=%h data=%h, required 000 55", b_user[b0+4], b_data[b0+4][31:0]);
    end
    feed_en = 1'b0; skip_to = src_n;
  endtask

  task automatic test_inst_only();
    int b0 = b_user.size(), c0 = n_cons, d0 = done_cnt;
    src_arr[src_n] = DATAW'(32'hDEAD); src_n += 1;
    feed_en = 1'b1;
    send_cmd(9'd7, 10'd0, 1'b0, 32'h1234_5678, 12'h003);
    wait_done(d0, 40, "inst");
    checks++;
    if (b_user.size() - b0 !== 1 || b_user[b0] !== 12'h000 ||
        b_data[b0] !== DATAW'(32'h1234_5678) || b_dest[b0] !== 12'h003) begin
      errors++;
      $display("FAIL inst_beat: n=%0d tuser=%h data=%h dest=%h, required 1 000 12345678 003",
               b_user.size() - b0, b_user[b0], b_data[b0][31:0], b_dest[b0]);
    end
    checks++;
    if (n_cons - c0 !== 0) begin
      errors++; $display("FAIL inst_consumed: got %0d, required 0", n_cons - c0);
    end
    feed_en = 1'b0; skip_to = src_n;
  endtask

  task automatic test_err();
    int b0 = b_user.size(), e0 = err_cnt;
    bit bad = 1'b0;
    send_cmd(9'd0, 10'd513, 1'b1, 32'h0, 12'h000);
    repeat (6) begin
      @(negedge clk);
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || tx_tvalid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL err_idle: cmd_ready/busy/tvalid left idle values, required 1/0/0");
    end
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++; $display("FAIL err_pulse: got %0d cycles, required 1", err_cnt - e0);
    end
    checks++;
    if (b_user.size() - b0 !== 0) begin
      errors++; $display("FAIL err_beats: got %0d, required 0", b_user.size() - b0);
    end
  endtask

  task automatic test_stall();
    int b0 = b_user.size(), d0 = done_cnt, s0 = stall_viol;
    logic [11:0]      eu;
    logic [DATAW-1:0] ed;
    for (int i = 0; i < 17; i++) src_arr[src_n+i] = DATAW'(32'h1000 + i * 7);
    src_n += 17;
    feed_en = 1'b1; gap_en = 1'b1; rdy_rand = 1'b1;
    send_cmd(9'd100, 10'd16, 1'b1, 32'hCAFE, 12'h005);
    wait_done(d0, 600, "stall");
    rdy_rand = 1'b0; gap_en = 1'b0; feed_en = 1'b0;
    checks++;
    if (b_user.size() - b0 !== 18) begin
      errors++; $display("FAIL stall_nbeats: got %0d, required 18", b_user.size() - b0);
    end
    for (int i = 0; i < 18; i++) begin
      if (i < 16)       begin eu = {3'b111, 9'(100 + i)}; ed = DATAW'(32'h1000 + i * 7); end
      else if (i == 16) begin eu = 12'h400; ed = DATAW'(32'h1000 + 16 * 7); end
      else              begin eu = 12'h000; ed = DATAW'(32'hCAFE); end
      checks++;
      if (b_user[b0+i] !== eu || b_data[b0+i] !== ed || b_meta[b0+i] !== 1'b1) begin
        errors++;
        $display("FAIL stall_beat%0d: tuser=%h data=%h meta=%b, required %h %h 1",
                 i, b_user[b0+i], b_data[b0+i][31:0], b_meta[b0+i], eu, ed[31:0]);
      end
    end
    checks++;
    if (stall_viol - s0 !== 0) begin
      errors++; $display("FAIL stall_hold: %0d held beats changed, required 0", stall_viol - s0);
    end
    skip_to = src_n;
  endtask

  task automatic test_reset_mid();
    int b0 = b_user.size(), n = 0, d0;
    logic [9:0] obs;
    for (int i = 0; i < 8; i++) src_arr[src_n+i] = DATAW'(32'h70 + i);
    src_n += 8;
    feed_en = 1'b1;
    send_cmd(9'd0, 10'd8, 1'b0, 32'h99, 12'h009);
    while (b_user.size() - b0 < 2 && n < 40) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    obs = {tx_tvalid, tx_tlast, |tx_tdata, |tx_tuser, |tx_tdest,
           cmd_ready, data_ready, busy, done, err};
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL rstmid_outputs: got %b, required %b", obs, 10'b0);
    end
    feed_en = 1'b0; skip_to = src_n;
    repeat (3) @(negedge clk);
    checks++;
    if (b_user.size() - b0 !== 2) begin
      errors++; $display("FAIL rstmid_beats: got %0d, required 2", b_user.size() - b0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    b0 = b_user.size(); d0 = done_cnt;
    send_cmd(9'd0, 10'd0, 1'b0, 32'h77, 12'h004);
    wait_done(d0, 40, "rstmid");
    checks++;
    if (b_user.size() - b0 !== 1 || b_data[b0] !== DATAW'(32'h77) || b_dest[b0] !== 12'h004) begin
      errors++;
      $display("FAIL rstmid_newjob: n=%0d data=%h dest=%h, required 1 77 004",
               b_user.size() - b0, b_data[b0][31:0], b_dest[b0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_inst_only();
    test_err();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
